// File: rtl/ones_count_accumulator.sv
// ---------------------------------------------------------------------------
// ones_count_accumulator
//
// Accumulates 2-bit upstream ones counts {y1,y0} (0..3) into a frame sum.
// A frame closes when FRAME_LEN counts have been accepted, or early on a
// flush once at least one count belongs to the frame. The closed frame is
// held on sum/n_samples/ovf with out_valid=1 until the downstream takes it
// (out_ready=1). After that, the accumulator clears and accepts counts again
// on the following cycle.
//
// Parameters
//   FRAME_LEN : counts per frame (2..255)
//   SUM_W     : width of the accumulated sum (2..16); the sum saturates
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream count valid
//   in_ready   : block accepts a count this cycle (ACCUM state)
//   y1, y0     : upstream count, MSB and LSB
//   flush      : close the current partial frame early
//   out_valid  : frame result is held (HOLD state)
//   out_ready  : downstream consumes the result
//   sum        : saturated total of the frame
//   n_samples  : number of counts accepted in the frame
//   ovf        : the frame sum saturated
// ---------------------------------------------------------------------------
module ones_count_accumulator #(
   parameter int FRAME_LEN = 8,
   parameter int SUM_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             y1,
   input  logic             y0,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] sum,
   output logic [7:0]       n_samples,
   output logic             ovf
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [7:0]       FRAME_LEN_B = 8'(FRAME_LEN);
   localparam logic [SUM_W-1:0] SUM_MAX     = '1;

   state_t           state_reg;
   logic [SUM_W-1:0] sum_reg;
   logic [7:0]       n_reg;
   logic             ovf_reg;

   logic             accept;
   logic [SUM_W:0]   sum_ext;      // one extra bit to detect overflow
   logic [7:0]       n_next;
   logic             frame_done;

   assign accept     = in_valid && (state_reg == ACCUM);
   assign sum_ext    = {1'b0, sum_reg} + {{(SUM_W-1){1'b0}}, y1, y0};
   assign n_next     = n_reg + 8'd1;
   // Close on the FRAME_LEN-th count, or on flush when the frame is non-empty
   // (counting a count accepted in this same cycle).
   assign frame_done = accept && ((n_next == FRAME_LEN_B) || flush) ||
                       (state_reg == ACCUM) && flush && (n_reg != 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ACCUM;
         sum_reg   <= '0;
         n_reg     <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (accept) begin
                  n_reg <= n_next;
                  if (sum_ext[SUM_W]) begin
                     sum_reg <= SUM_MAX;
                     ovf_reg <= 1'b1;
                  end else begin
                     sum_reg <= sum_ext[SUM_W-1:0];
                  end
               end
               if (frame_done)
                  state_reg <= HOLD;
            end
            HOLD: begin
               // Result stays frozen until the downstream takes it.
               if (out_ready) begin
                  state_reg <= ACCUM;
                  sum_reg   <= '0;
                  n_reg     <= '0;
                  ovf_reg   <= 1'b0;
               end
            end
            default: state_reg <= ACCUM;
         endcase
      end
   end

   assign in_ready  = (state_reg == ACCUM);
   assign out_valid = (state_reg == HOLD);
   assign sum       = sum_reg;
   assign n_samples = n_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ones_count_accumulator
//
// Directed bench: two instances share all inputs, one with FRAME_LEN=4,
// SUM_W=4 and one with FRAME_LEN=4, SUM_W=3 (checked for saturation).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// reflecting the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_ones_count_accumulator;

   logic       clk = 1'b0;
   logic       rst, in_valid, y1, y0, flush, out_ready;
   logic       in_ready_a, out_valid_a, ovf_a;
   logic [3:0] sum_a;
   logic [7:0] n_a;
   logic       in_ready_b, out_valid_b, ovf_b;
   logic [2:0] sum_b;
   logic [7:0] n_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ones_count_accumulator #(.FRAME_LEN(4), .SUM_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .y1(y1), .y0(y0), .flush(flush), .out_valid(out_valid_a),
      .out_ready(out_ready), .sum(sum_a), .n_samples(n_a), .ovf(ovf_a)
   );

   ones_count_accumulator #(.FRAME_LEN(4), .SUM_W(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .y1(y1), .y0(y0), .flush(flush), .out_valid(out_valid_b),
      .out_ready(out_ready), .sum(sum_b), .n_samples(n_b), .ovf(ovf_b)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_count(input int v);
      logic [1:0] c;
      c  = v[1:0];
      y1 = c[1];
      y0 = c[0];
   endtask

   task automatic feed(input int v, input string tag);
      set_count(v);
      step();
      $display("%s: count=%0d -> sum=%0d n=%0d out_valid=%0b", tag, v, sum_a, n_a, out_valid_a);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; y1 = 1'b0; y0 = 1'b0;
      flush = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready", int'(in_ready_a), 1);
      check("rst_out_valid", int'(out_valid_a), 0);
      check("rst_sum", int'(sum_a), 0);
      check("rst_n", int'(n_a), 0);
      check("rst_ovf", int'(ovf_a), 0);

      // Full frame 3,2,1,3
      in_valid = 1'b1;
      feed(3, "frame");
      feed(2, "frame");
      feed(1, "frame");
      check("frame3_sum", int'(sum_a), 6);
      check("frame3_n", int'(n_a), 3);
      check("frame3_out_valid", int'(out_valid_a), 0);
      feed(3, "frame");
      check("frame_out_valid", int'(out_valid_a), 1);
      check("frame_sum", int'(sum_a), 9);
      check("frame_n", int'(n_a), 4);
      check("frame_ovf", int'(ovf_a), 0);
      check("frame_in_ready", int'(in_ready_a), 0);

      // Backpressure: counts offered while held must be ignored
      for (int i = 0; i < 5; i++) begin
         feed((i + 1) % 4, "bp");
         check("bp_sum", int'(sum_a), 9);
         check("bp_n", int'(n_a), 4);
         check("bp_in_ready", int'(in_ready_a), 0);
         check("bp_out_valid", int'(out_valid_a), 1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      $display("consume: sum=%0d n=%0d in_ready=%0b", sum_a, n_a, in_ready_a);
      check("consume_sum", int'(sum_a), 0);
      check("consume_n", int'(n_a), 0);
      check("consume_in_ready", int'(in_ready_a), 1);
      check("consume_out_valid", int'(out_valid_a), 0);

      // Flush with a count accepted in the same cycle
      in_valid = 1'b1;
      feed(2, "flush");
      feed(1, "flush");
      flush = 1'b1;
      feed(3, "flush");
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", int'(out_valid_a), 1);
      check("flush_sum", int'(sum_a), 6);
      check("flush_n", int'(n_a), 3);
      // Flush while holding is ignored; result unchanged
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_hold_sum", int'(sum_a), 6);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      // Flush on an empty frame changes nothing
      flush = 1'b1;
      step();
      flush = 1'b0;
      $display("empty flush: n=%0d out_valid=%0b", n_a, out_valid_a);
      check("eflush_out_valid", int'(out_valid_a), 0);
      check("eflush_in_ready", int'(in_ready_a), 1);
      check("eflush_n", int'(n_a), 0);
      check("eflush_sum", int'(sum_a), 0);

      // Reset mid-frame, with in_valid still high
      in_valid = 1'b1;
      feed(1, "midrst");
      feed(1, "midrst");
      check("midrst_pre_n", int'(n_a), 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_sum", int'(sum_a), 0);
      check("midrst_n", int'(n_a), 0);
      check("midrst_in_ready", int'(in_ready_a), 1);
      for (int i = 0; i < 4; i++) feed(1, "ones");
      check("ones_sum", int'(sum_a), 4);
      check("ones_n", int'(n_a), 4);
      check("ones_out_valid", int'(out_valid_a), 1);

      // Reset during HOLD
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      $display("holdrst: sum=%0d out_valid=%0b in_ready=%0b", sum_a, out_valid_a, in_ready_a);
      check("holdrst_out_valid", int'(out_valid_a), 0);
      check("holdrst_in_ready", int'(in_ready_a), 1);
      check("holdrst_sum", int'(sum_a), 0);
      check("holdrst_n", int'(n_a), 0);

      // Saturation on the SUM_W=3 instance: 3,3,3,1
      in_valid = 1'b1;
      feed(3, "sat");
      feed(3, "sat");
      check("sat2_sum", int'(sum_b), 6);
      check("sat2_ovf", int'(ovf_b), 0);
      feed(3, "sat");
      feed(1, "sat");
      in_valid = 1'b0;
      $display("sat: sum3=%0d ovf3=%0b n3=%0d", sum_b, ovf_b, n_b);
      check("sat_sum", int'(sum_b), 7);
      check("sat_ovf", int'(ovf_b), 1);
      check("sat_n", int'(n_b), 4);
      check("sat_out_valid", int'(out_valid_b), 1);
      check("sat_wide_sum", int'(sum_a), 10);
      check("sat_wide_ovf", int'(ovf_a), 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("sat_clear_ovf", int'(ovf_b), 0);
      check("sat_clear_sum", int'(sum_b), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ones_count_accumulator.md
ONES_COUNT_ACCUMULATOR -- requirements
Module: ones_count_accumulator

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: number of 2-bit counts per frame, legal range 2..255.
REQ-002 SHALL have parameter SUM_W, default 5: width of the accumulated sum, legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream count {y1,y0} is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a count this cycle.
REQ-007 SHALL have port y1  input  1  MSB of the upstream 3-input ones count (carry).
REQ-008 SHALL have port y0  input  1  LSB of the upstream 3-input ones count (sum).
REQ-009 SHALL have port flush  input  1  close the current partial frame early.
REQ-010 SHALL have port out_valid  output  1  frame result held on sum/n_samples/ovf.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-012 SHALL have port sum  output  SUM_W  total of the counts accepted in the frame.
REQ-013 SHALL have port n_samples  output  8  number of counts accepted in the frame.
REQ-014 SHALL have port ovf  output  1  the frame sum saturated.

Function
REQ-015 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 SHALL accept a count only when in_valid=1 and in_ready=1; the accepted value is {y1,y0} (0..3).
REQ-017 SHALL, on acceptance, register sum <= sum+{y1,y0} and n_samples <= n_samples+1, with the new values visible on the next cycle.
REQ-018 SHALL saturate sum at 2^SUM_W-1 when the addition exceeds it, and set ovf=1 until the frame is consumed.
REQ-019 SHALL move ACCUM->HOLD on the cycle that accepts the FRAME_LEN-th count; out_valid rises on the following cycle.
REQ-020 SHALL move ACCUM->HOLD when flush=1 and (n_samples>0 or a count is accepted in the same cycle); a count accepted together with flush is included in the result.
REQ-021 SHALL ignore flush when n_samples=0 and no count is accepted that cycle, and SHALL ignore flush in HOLD.
REQ-022 SHALL keep sum, n_samples and ovf stable throughout HOLD until out_ready=1.
REQ-023 SHALL, in HOLD with out_ready=1, move to ACCUM and clear sum, n_samples and ovf to 0 on the next cycle; in_ready returns to 1 that next cycle (no same-cycle bypass).
REQ-024 SHALL ignore y1, y0 and in_valid while in_ready=0; no count is lost or double-counted.
REQ-025 SHALL keep out_valid asserted until out_ready is sampled high (no retraction).

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter ACCUM with sum=0, n_samples=0, ovf=0, out_valid=0, in_ready=1, regardless of the current state.
REQ-027 SHALL give rst priority over in_valid, flush and out_ready in the same cycle; a partial or held frame is discarded.

Verification (FRAME_LEN=4, SUM_W=4 unless stated)
REQ-028 SHALL cover a full frame: counts 3,2,1,3 with in_valid held high -> out_valid=1 one cycle after the 4th, sum=9, n_samples=4, ovf=0, in_ready=0.
REQ-029 SHALL cover saturation: SUM_W=3, counts 3,3,3,1 -> sum=7, ovf=1, n_samples=4.
REQ-030 SHALL cover flush: counts 2,1, then 3 accepted with flush=1 -> sum=6, n_samples=3; flush=1 with n_samples=0 and in_valid=0 -> no state change.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 and changing y1/y0 -> result unchanged, in_ready=0; out_ready=1 -> next cycle sum=0, in_ready=1.
REQ-032 SHALL cover reset mid-frame and in HOLD: rst=1 after 2 counts or during HOLD -> next cycle sum=0, n_samples=0, out_valid=0, in_ready=1; a following frame of 1,1,1,1 yields sum=4.
